// File: rtl/sigmoid_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sigmoid_pkg                                                     |
// | Purpose  : Shared FP widths, rounding/exception encodings and FSM states   |
// |            for the shared sigmoid controller.                              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package sigmoid_pkg;

  localparam int EXP_WIDTH  = 8;
  localparam int MANT_WIDTH = 24;
  localparam int DW         = EXP_WIDTH + MANT_WIDTH;

  localparam int EXC_W         = 5;
  localparam int EXC_INVALID   = 0;
  localparam int EXC_DIVZERO   = 1;
  localparam int EXC_OVERFLOW  = 2;
  localparam int EXC_UNDERFLOW = 3;
  localparam int EXC_INEXACT   = 4;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } round_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } ctrl_state_t;

  // Modulo-n increment used for round-robin pointer advance.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                      |
// | Purpose  : Combinational round-robin arbiter; scans from ptr upward.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW:0] w_pos;
  logic        w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, ptr} + (IW+1)'(k);
      if (w_pos >= (IW+1)'(N)) begin
        w_pos = w_pos - (IW+1)'(N);
      end
      if (!w_found && req[w_pos[IW-1:0]]) begin
        gnt[w_pos[IW-1:0]] = 1'b1;
        gnt_idx            = w_pos[IW-1:0];
        w_found            = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sigmoid_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sigmoid_share_ctrl                                              |
// | Purpose  : Time-shares one non-pipelined sigmoid unit among N_REQ          |
// |            requesters with round-robin arbitration and tagged responses.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sigmoid_share_ctrl #(
  parameter  int N_REQ       = 4,
  parameter  int EXP_WIDTH   = sigmoid_pkg::EXP_WIDTH,
  parameter  int MANT_WIDTH  = sigmoid_pkg::MANT_WIDTH,
  parameter  int SIG_LATENCY = 32,
  localparam int DW          = EXP_WIDTH + MANT_WIDTH,
  localparam int IDW         = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*DW-1:0]           req_x,
  input  logic [2:0]                    round_mode,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [IDW-1:0]                resp_id,
  output logic [DW-1:0]                 resp_y,
  output logic [sigmoid_pkg::EXC_W-1:0] resp_exc,
  output logic [DW-1:0]                 sig_x,
  output logic [2:0]                    sig_round_mode,
  input  logic [DW-1:0]                 sig_y,
  input  logic [sigmoid_pkg::EXC_W-1:0] sig_exc,
  output logic                          busy
);

  import sigmoid_pkg::*;

  localparam int             CW         = (SIG_LATENCY > 1) ? $clog2(SIG_LATENCY) : 1;
  localparam logic [CW-1:0]  C_CNT_LOAD = CW'(SIG_LATENCY - 1);

  ctrl_state_t       r_state;
  logic [IDW-1:0]    r_rr_ptr;
  logic [IDW-1:0]    r_id_q;
  logic [CW-1:0]     r_counter;
  logic [DW-1:0]     r_sig_x;
  round_mode_t       r_sig_rm;
  logic              r_resp_valid;
  logic [IDW-1:0]    r_resp_id;
  logic [DW-1:0]     r_resp_y;
  logic [EXC_W-1:0]  r_resp_exc;

  logic [DW-1:0]     w_x [N_REQ];
  logic [N_REQ-1:0]  w_gnt;
  logic [IDW-1:0]    w_gnt_idx;
  logic              w_accept;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign w_x[i] = req_x[i*DW +: DW];
  end

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // Grants are only offered while idle, so at most one job is ever in flight.
  assign req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign w_accept  = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_id_q       <= '0;
      r_counter    <= '0;
      r_sig_x      <= '0;
      r_sig_rm     <= RNE;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_y     <= '0;
      r_resp_exc   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sig_x   <= w_x[w_gnt_idx];
            r_sig_rm  <= round_mode_t'(round_mode);
            r_id_q    <= w_gnt_idx;
            r_counter <= C_CNT_LOAD;
            r_rr_ptr  <= IDW'(wrap_inc(int'(w_gnt_idx), N_REQ));
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          // sig_x has been held SIG_LATENCY cycles when the counter reaches zero.
          if (r_counter == '0) begin
            r_resp_y     <= sig_y;
            r_resp_exc   <= sig_exc;
            r_resp_id    <= r_id_q;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_counter <= r_counter - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy           = (r_state != IDLE);
  assign sig_x          = r_sig_x;
  assign sig_round_mode = r_sig_rm;
  assign resp_valid     = r_resp_valid;
  assign resp_id        = r_resp_id;
  assign resp_y         = r_resp_y;
  assign resp_exc       = r_resp_exc;

endmodule

`default_nettype wire

// File: tb/tb_sigmoid_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sigmoid_share_ctrl                                           |
// | Purpose  : Self-checking bench with a stub sigmoid unit and a round-robin  |
// |            reference model.                                                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_sigmoid_share_ctrl;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int LAT = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_x = '0;
  logic [2:0]      round_mode = 3'b000;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [1:0]      resp_id;
  logic [DW-1:0]   resp_y;
  logic [4:0]      resp_exc;
  logic [DW-1:0]   sig_x;
  logic [2:0]      sig_round_mode;
  logic [DW-1:0]   sig_y;
  logic [4:0]      sig_exc;
  logic            busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sigmoid_share_ctrl #(
    .N_REQ       (N),
    .EXP_WIDTH   (8),
    .MANT_WIDTH  (24),
    .SIG_LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_x          (req_x),
    .round_mode     (round_mode),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_y         (resp_y),
    .resp_exc       (resp_exc),
    .sig_x          (sig_x),
    .sig_round_mode (sig_round_mode),
    .sig_y          (sig_y),
    .sig_exc        (sig_exc),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stub sigmoid unit: result only defined once sig_x has been stable LAT cycles.
  int          stab = 0;
  logic [31:0] prev_x;
  logic [2:0]  prev_rm;
  logic        prev_issue = 1'b0;
  logic        cur_issue;

  assign sig_y   = (stab >= LAT) ? (sig_x ^ 32'h8000_0000) : 'x;
  assign sig_exc = (stab >= LAT) ? ((sig_x == 32'h7FC0_0000) ? 5'b00001 : 5'b00000) : 'x;

  always @(negedge clk) begin
    cur_issue = busy && !resp_valid;
    if (cur_issue && prev_issue) begin
      chk("sig_x_stable", sig_x, prev_x);
      chk("sig_rm_stable", 32'(sig_round_mode), 32'(prev_rm));
    end
    if (sig_x !== prev_x) stab = 1;
    else if (stab < 1000) stab++;
    prev_x     = sig_x;
    prev_rm    = sig_round_mode;
    prev_issue = cur_issue;
  end

  // Reference model
  int          m_ptr = 0;
  logic [31:0] xs [N];

  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_y(input logic [31:0] x);
    return x ^ 32'h8000_0000;
  endfunction

  function automatic logic [31:0] model_exc(input logic [31:0] x);
    return (x == 32'h7FC0_0000) ? 32'd1 : 32'd0;
  endfunction

  task automatic set_x(input int i, input logic [31:0] v);
    xs[i] = v;
    req_x[i*DW +: DW] = v;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_job(input bit drop, input int bp, input logic [2:0] rm,
                         input logic [2:0] rm_after, output int gid, output time t_acc);
    int          g;
    int          n;
    logic [31:0] x;
    g     = model_grant(req_valid, m_ptr);
    gid   = g;
    t_acc = 0;
    round_mode = rm;
    #1;
    chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    if (g < 0) return;
    x = xs[g];
    @(negedge clk);
    t_acc = $time;
    m_ptr = (g + 1) % N;
    if (drop) req_valid[g] = 1'b0;
    round_mode = rm_after;
    chk("sig_x_latched", sig_x, x);
    chk("sig_rm_latched", 32'(sig_round_mode), 32'(rm));
    chk("busy_issue", 32'(busy), 32'd1);
    n = 0;
    while (!resp_valid && n < LAT + 10) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, LAT);
    chk("resp_id", 32'(resp_id), g);
    chk("resp_y", resp_y, model_y(x));
    chk("resp_exc", 32'(resp_exc), model_exc(x));
    chk("sig_rm_held", 32'(sig_round_mode), 32'(rm));
    for (int b = 0; b < bp; b++) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_id", 32'(resp_id), g);
      chk("bp_y", resp_y, model_y(x));
      chk("bp_exc", 32'(resp_exc), model_exc(x));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_done", 32'(resp_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  gid;
    time t_acc;
    time t_prev;
    bit  saw;
    int  order [5];

    for (int i = 0; i < N; i++) set_x(i, 32'h0);

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_y", resp_y, 32'd0);
    chk("rst_resp_exc", 32'(resp_exc), 32'd0);
    chk("rst_sig_x", sig_x, 32'd0);
    chk("rst_sig_rm", 32'(sig_round_mode), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    m_ptr = 0;
    @(negedge clk);

    // Single request from requester 2
    set_x(2, 32'h3F80_0000);
    req_valid = 4'b0100;
    run_job(1'b1, 0, 3'b000, 3'b000, gid, t_acc);

    // Continuous requests from all four, after a pointer reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) set_x(i, 32'h4000_0000 + i);
    req_valid = 4'b1111;
    t_prev = 0;
    for (int j = 0; j < 5; j++) begin
      run_job(1'b0, 0, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), order[j], t_acc);
      chk("cont_order", order[j], j % N);
      if (j > 0) chk("accept_spacing", 32'(t_acc - t_prev), 32'd340);
      t_prev = t_acc;
    end
    req_valid = '0;

    // Backpressure, then next grant follows the pointer
    for (int i = 0; i < N; i++) set_x(i, $urandom);
    req_valid = 4'b1111;
    run_job(1'b1, 10, 3'b010, 3'b011, gid, t_acc);
    req_valid = 4'b1111;
    run_job(1'b1, 0, 3'b000, 3'b000, gid, t_acc);
    req_valid = '0;

    // NaN passthrough with round mode changed after accept
    set_x(3, 32'h7FC0_0000);
    req_valid = 4'b1000;
    run_job(1'b1, 2, 3'b001, 3'b000, gid, t_acc);
    chk("nan_resp_y_const", resp_y, 32'hFFC0_0000);
    req_valid = '0;

    // Random jobs
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < N; i++) set_x(i, $urandom);
      req_valid = 4'($urandom_range(1, 15));
      run_job(1'b1, int'($urandom_range(0, 3)), 3'($urandom_range(0, 4)),
              3'($urandom_range(0, 4)), gid, t_acc);
      req_valid = '0;
    end

    // Reset during ISSUE discards the job and the round-robin pointer
    set_x(1, $urandom);
    req_valid = 4'b0010;
    round_mode = 3'b011;
    #1;
    chk("rst_job_ready", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid = '0;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    m_ptr = 0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_sig_x", sig_x, 32'd0);
    chk("midrst_sig_rm", 32'(sig_round_mode), 32'd0);
    rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) saw = 1'b1;
    end
    chk("no_resp_after_rst", 32'(saw), 32'd0);
    set_x(0, $urandom);
    set_x(3, $urandom);
    req_valid = 4'b1001;
    run_job(1'b1, 0, 3'b100, 3'b000, gid, t_acc);
    req_valid = '0;

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
